niosii_system_sysid_checker: RTL and testbench
==============================================

Name: niosII_system_sysid_checker

Overview:
- Avalon-MM read master; the initiator side of the system-ID control slave.
- After reset, or on request, it reads the ID word (word address 0) and the timestamp word (word address 1).
- Compares both against build-time expected values and reports match, mismatch or timeout as sticky status.
- Sits next to the sysid slave on the interconnect and gates downstream boot logic on a verified hardware build.

Parameters:
- EXPECTED_ID, 32'h0000_0000, value required at word address 0
- EXPECTED_TIMESTAMP, 32'h58B0_B725, value required at word address 1
- TIMEOUT_CYCLES, 255, max cycles per read transaction (request plus response); range 2..65535
- AUTO_START, 1, 1 = run one check automatically after reset release

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run a check
- avm_address  out  1  word address to sysid slave
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier
- busy  out  1  check in progress
- done  out  1  one-cycle pulse at end of each check
- id_ok  out  1  sticky: ID matched
- ts_ok  out  1  sticky: timestamp matched
- timeout  out  1  sticky: last check aborted on timeout
- id_value  out  32  last ID captured
- ts_value  out  32  last timestamp captured

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE.
  - All outputs 0; avm_address 0.
  - Internal auto-start flag set to AUTO_START.
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH.
- IDLE:
  - Leaves to ID_REQ when start=1 or the auto-start flag is set; the flag clears on that transition.
  - On leaving, clears id_ok, ts_ok and timeout; id_value and ts_value are retained until overwritten.
- ID_REQ:
  - avm_read=1, avm_address=0, both held stable while avm_waitrequest=1.
  - Transfer is accepted on the cycle avm_read=1 and avm_waitrequest=0; next state ID_WAIT.
  - If avm_readdatavalid=1 on the accept cycle, capture immediately and go to TS_REQ.
- ID_WAIT:
  - avm_read=0.
  - On avm_readdatavalid=1: id_value<=avm_readdata and id_ok<=(avm_readdata==EXPECTED_ID); next state TS_REQ.
- TS_REQ / TS_WAIT: identical rules with avm_address=1; capture into ts_value and ts_ok, compared against EXPECTED_TIMESTAMP; next state FINISH.
- FINISH: done=1 for exactly one cycle; next state IDLE.
- busy=1 in every state except IDLE; done is not gated by busy.
- Timeout counter:
  - 16-bit; cleared on entry to ID_REQ and to TS_REQ; increments each cycle in REQ/WAIT states.
  - When it equals TIMEOUT_CYCLES-1 with no acceptance/capture that cycle: timeout<=1, avm_read<=0, go to FINISH.
  - The ok flag for the aborted word stays 0, and the remaining read is skipped.
  - Capture on the final cycle takes priority over timeout.
- avm_readdatavalid outside ID_WAIT/TS_WAIT, or outside the accept cycle, is ignored; this covers a late response after a timeout.
- start while busy=1 is ignored (not queued). start in FINISH is ignored; start in IDLE on the cycle after FINISH is accepted.
- Reset asserted mid-transaction: immediate return to reset values. avm_read drops asynchronously; no recovery of a pending response.
- Only one outstanding read at a time; avm_read is never asserted in WAIT states.

Test Plan:
- Reset release, AUTO_START=1, slave returns 0 at address 0 and 32'h58B0B725 at address 1, zero waitrequest, one-cycle readdatavalid latency -> two reads at addresses 0 then 1; done pulses once; id_ok=1, ts_ok=1, timeout=0; busy high 5 cycles.
- Slave returns 32'h58B0B726 for timestamp -> ts_ok=0, id_ok=1, ts_value=32'h58B0B726, done pulses.
- waitrequest held 3 cycles on each read -> avm_read and avm_address stable throughout the stall; results as in scenario 1; busy lasts 3 cycles longer per read.
- TIMEOUT_CYCLES=8, no readdatavalid for the ID read -> timeout=1 and done exactly 8 cycles after ID_REQ entry; no address-1 read issued; id_ok=ts_ok=0; a stray readdatavalid 2 cycles later leaves id_value unchanged.
- start pulsed twice during busy, then once in IDLE -> exactly two checks run in total; sticky flags clear at the second check's start.
- reset_n pulled low during TS_WAIT -> all outputs 0 immediately; after release with AUTO_START=1 a full check reruns from address 0.

Source files
------------

// File: rtl/niosii_system_sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the
// system-ID slave.
//   avm_address       : word address (0 = ID, 1 = timestamp)
//   avm_read          : read request
//   avm_waitrequest   : slave stall
//   avm_readdata      : read data
//   avm_readdatavalid : read data qualifier
interface niosii_system_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/niosii_system_sysid_checker.sv
// System-ID checker: Avalon-MM read master that fetches the sysid ID word
// (address 0) and timestamp word (address 1), compares them with build-time
// constants and reports sticky match / timeout status.
//   clock, reset_n : system clock, asynchronous active-low reset
//   start          : single-cycle request to run a check (ignored while busy)
//   avm            : Avalon-MM master side towards the sysid slave
//   busy           : check in progress
//   done           : one-cycle pulse at the end of each check
//   id_ok, ts_ok   : sticky match flags for the last check
//   timeout        : sticky, last check aborted on timeout
//   id_value       : last ID captured
//   ts_value       : last timestamp captured
module niosii_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h58B0_B725,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                start,
    niosii_system_sysid_checker_if.master       avm,
    output logic                                busy,
    output logic                                done,
    output logic                                id_ok,
    output logic                                ts_ok,
    output logic                                timeout,
    output logic [31:0]                         id_value,
    output logic [31:0]                         ts_value
);

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        FINISH
    } state_t;

    localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [15:0] cnt;
    logic        auto_flag;
    logic        go, cnt_clr, cap_id, cap_ts, set_timeout;
    logic        last;

    // ">=" rather than "==": a request accepted on the final cycle moves to
    // WAIT with the counter already past the limit, so it must still expire.
    assign last = (cnt >= LAST_CYCLE);

    always_comb begin
        state_next  = state;
        go          = 1'b0;
        cnt_clr     = 1'b0;
        cap_id      = 1'b0;
        cap_ts      = 1'b0;
        set_timeout = 1'b0;
        unique case (state)
            IDLE: begin
                if (start || auto_flag) begin
                    go         = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ID_REQ;
                end
            end
            ID_REQ: begin
                if (!avm.avm_waitrequest) begin
                    if (avm.avm_readdatavalid) begin
                        cap_id     = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = TS_REQ;
                    end else begin
                        state_next = ID_WAIT;
                    end
                end else if (last) begin
                    set_timeout = 1'b1;
                    state_next  = FINISH;
                end
            end
            ID_WAIT: begin
                if (avm.avm_readdatavalid) begin
                    cap_id     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = TS_REQ;
                end else if (last) begin
                    set_timeout = 1'b1;
                    state_next  = FINISH;
                end
            end
            TS_REQ: begin
                if (!avm.avm_waitrequest) begin
                    if (avm.avm_readdatavalid) begin
                        cap_ts     = 1'b1;
                        state_next = FINISH;
                    end else begin
                        state_next = TS_WAIT;
                    end
                end else if (last) begin
                    set_timeout = 1'b1;
                    state_next  = FINISH;
                end
            end
            TS_WAIT: begin
                if (avm.avm_readdatavalid) begin
                    cap_ts     = 1'b1;
                    state_next = FINISH;
                end else if (last) begin
                    set_timeout = 1'b1;
                    state_next  = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs decode straight from the state register so that reset
    // removes avm_read asynchronously.
    always_comb begin
        avm.avm_read    = (state == ID_REQ) || (state == TS_REQ);
        avm.avm_address = (state == TS_REQ) || (state == TS_WAIT);
        busy            = (state != IDLE);
        done            = (state == FINISH);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            auto_flag <= AUTO_START;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
            id_value  <= '0;
            ts_value  <= '0;
        end else begin
            state <= state_next;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state inside {ID_REQ, ID_WAIT, TS_REQ, TS_WAIT}) begin
                cnt <= cnt + 16'd1;
            end
            if (go) begin
                auto_flag <= 1'b0;
                id_ok     <= 1'b0;
                ts_ok     <= 1'b0;
                timeout   <= 1'b0;
            end
            if (cap_id) begin
                id_value <= avm.avm_readdata;
                id_ok    <= (avm.avm_readdata == EXPECTED_ID);
            end
            if (cap_ts) begin
                ts_value <= avm.avm_readdata;
                ts_ok    <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Self-checking bench for niosii_system_sysid_checker: behavioural sysid
// slave with configurable stall / mute, scoreboard of expected check results
// popped by a monitor on every done pulse.
module tb_niosii_system_sysid_checker;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    niosii_system_sysid_checker_if bus ();

    niosii_system_sysid_checker #(
        .EXPECTED_ID        (32'h0000_0000),
        .EXPECTED_TIMESTAMP (32'h58B0_B725),
        .TIMEOUT_CYCLES     (8),
        .AUTO_START         (1'b1)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .avm      (bus.master),
        .busy     (busy),
        .done     (done),
        .id_ok    (id_ok),
        .ts_ok    (ts_ok),
        .timeout  (timeout),
        .id_value (id_value),
        .ts_value (ts_value)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          busy_cycles;
        int          rd0;
        int          rd1;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;

    // slave configuration
    logic [31:0] id_word, ts_word, stray_data;
    int          stall_cfg;
    logic        mute_id, stray_req;
    int          rd0_cnt, rd1_cnt;
    int          busy_cnt, done_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic i_ok, input logic t_ok, input logic tmo,
                                input logic [31:0] idv, input logic [31:0] tsv,
                                input int bc, input int r0, input int r1);
        exp_t e;
        e.id_ok = i_ok; e.ts_ok = t_ok; e.tmo = tmo;
        e.idv = idv; e.tsv = tsv;
        e.busy_cycles = bc; e.rd0 = r0; e.rd1 = r1;
        return e;
    endfunction

    // Behavioural slave: decisions made on the falling edge, seen by the DUT
    // on the following rising edge. Read data arrives one cycle after accept.
    initial begin : slave
        logic        pending, prev_wr, prev_addr, in_read;
        logic [31:0] pending_data;
        int          stall_left;
        pending = 0; prev_wr = 0; prev_addr = 0; in_read = 0; stall_left = 0;
        pending_data = '0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                pending = 0; prev_wr = 0; in_read = 0;
                bus.avm_waitrequest   = 1'b0;
                bus.avm_readdatavalid = 1'b0;
                rd0_cnt = 0; rd1_cnt = 0;
            end else begin
                if (prev_wr) begin
                    check("stall_read_held", {31'd0, bus.avm_read}, 32'd1);
                    check("stall_addr_held", {31'd0, bus.avm_address}, {31'd0, prev_addr});
                end
                if (stray_req) begin
                    bus.avm_readdatavalid = 1'b1;
                    bus.avm_readdata      = stray_data;
                    stray_req             = 1'b0;
                end else begin
                    bus.avm_readdatavalid = pending;
                    bus.avm_readdata      = pending ? pending_data : '0;
                end
                pending = 0;
                if (bus.avm_read) begin
                    if (!in_read) begin
                        in_read    = 1;
                        stall_left = stall_cfg;
                    end
                    if (stall_left > 0) begin
                        bus.avm_waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        bus.avm_waitrequest = 1'b0;
                        in_read = 0;
                        if (bus.avm_address) rd1_cnt++; else rd0_cnt++;
                        pending      = !(mute_id && !bus.avm_address);
                        pending_data = bus.avm_address ? ts_word : id_word;
                    end
                end else begin
                    bus.avm_waitrequest = 1'b0;
                end
                prev_wr   = bus.avm_waitrequest;
                prev_addr = bus.avm_address;
            end
        end
    end

    // Monitor: pops one expectation per done pulse.
    initial begin : monitor
        exp_t e;
        busy_cnt = 0;
        done_cnt = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    done_cnt++;
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_done: got done=1 expected no check pending at %0t", $time);
                    end else begin
                        e = q.pop_front();
                        check("id_ok",    {31'd0, id_ok},   {31'd0, e.id_ok});
                        check("ts_ok",    {31'd0, ts_ok},   {31'd0, e.ts_ok});
                        check("timeout",  {31'd0, timeout}, {31'd0, e.tmo});
                        check("id_value", id_value, e.idv);
                        check("ts_value", ts_value, e.tsv);
                        check("busy_cycles", busy_cnt, e.busy_cycles);
                        check("reads_addr0", rd0_cnt, e.rd0);
                        check("reads_addr1", rd1_cnt, e.rd1);
                    end
                    busy_cnt = 0;
                    rd0_cnt  = 0;
                    rd1_cnt  = 0;
                end
            end
        end
    end

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        @(negedge clock);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    {31'd0, busy},    32'd0);
        check({tag, "_done"},    {31'd0, done},    32'd0);
        check({tag, "_id_ok"},   {31'd0, id_ok},   32'd0);
        check({tag, "_ts_ok"},   {31'd0, ts_ok},   32'd0);
        check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        check({tag, "_id_value"}, id_value, 32'd0);
        check({tag, "_ts_value"}, ts_value, 32'd0);
        check({tag, "_read"},    {31'd0, bus.avm_read},    32'd0);
        check({tag, "_address"}, {31'd0, bus.avm_address}, 32'd0);
    endtask

    localparam logic [31:0] TS_GOOD = 32'h58B0_B725;
    localparam logic [31:0] TS_BAD  = 32'h58B0_B726;

    initial begin : stim
        bit found;
        int dc0;
        reset_n    = 1'b0;
        start      = 1'b0;
        id_word    = 32'h0000_0000;
        ts_word    = TS_GOOD;
        stall_cfg  = 0;
        mute_id    = 1'b0;
        stray_req  = 1'b0;
        stray_data = 32'hDEAD_BEEF;
        rd0_cnt    = 0;
        rd1_cnt    = 0;

        // reset state
        #3;
        check_all_zero("reset");
        repeat (3) @(negedge clock);

        // 1: auto-start check after reset release
        q.push_back(mk(1, 1, 0, 32'h0, TS_GOOD, 5, 1, 1));
        reset_n = 1'b1;
        wait_done(40);

        // 2: timestamp mismatch
        ts_word = TS_BAD;
        q.push_back(mk(1, 0, 0, 32'h0, TS_BAD, 5, 1, 1));
        pulse_start();
        wait_done(40);

        // 3: three-cycle waitrequest on each read
        ts_word   = TS_GOOD;
        stall_cfg = 3;
        q.push_back(mk(1, 1, 0, 32'h0, TS_GOOD, 11, 1, 1));
        pulse_start();
        wait_done(60);
        stall_cfg = 0;

        // 4: ID response never arrives -> timeout, then a stray response
        mute_id = 1'b1;
        q.push_back(mk(0, 0, 1, 32'h0, TS_GOOD, 9, 1, 0));
        pulse_start();
        wait_done(60);
        mute_id = 1'b0;
        @(negedge clock);
        stray_req = 1'b1;
        repeat (4) @(negedge clock);
        check("stray_id_value", id_value, 32'h0);
        check("stray_ts_value", ts_value, TS_GOOD);
        check("stray_timeout",  {31'd0, timeout}, 32'd1);
        check("stray_idle",     {31'd0, busy},    32'd0);

        // 5: starts while busy and in FINISH are dropped
        dc0 = done_cnt;
        ts_word = TS_BAD;
        q.push_back(mk(1, 0, 0, 32'h0, TS_BAD, 5, 1, 1));
        @(negedge clock); start = 1'b1;      // IDLE: accepted
        @(negedge clock); start = 1'b0;      // ID_REQ
        @(negedge clock); start = 1'b1;      // ID_WAIT: ignored
        @(negedge clock); start = 1'b0;      // TS_REQ
        @(negedge clock);                    // TS_WAIT
        @(negedge clock); start = 1'b1;      // FINISH: ignored
        @(negedge clock); start = 1'b0;      // IDLE
        @(negedge clock);
        check("no_queued_start", {31'd0, busy}, 32'd0);
        ts_word = TS_GOOD;
        q.push_back(mk(1, 1, 0, 32'h0, TS_GOOD, 5, 1, 1));
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        check("flags_clear_id_ok",   {31'd0, id_ok}, 32'd0);
        check("flags_clear_ts_ok",   {31'd0, ts_ok}, 32'd0);
        check("second_check_busy",   {31'd0, busy},  32'd1);
        wait_done(40);
        repeat (10) @(negedge clock);
        check("two_checks_total", done_cnt - dc0, 32'd2);

        // 6: reset during TS_WAIT, auto rerun afterwards
        q.push_back(mk(1, 1, 0, 32'h0, TS_GOOD, 5, 1, 1));
        pulse_start();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (busy && bus.avm_address && !bus.avm_read) found = 1;
            else @(negedge clock);
        end
        check("reached_ts_wait", {31'd0, found}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        void'(q.pop_back());
        repeat (3) @(negedge clock);
        q.push_back(mk(1, 1, 0, 32'h0, TS_GOOD, 5, 1, 1));
        reset_n = 1'b1;
        wait_done(40);

        repeat (5) @(negedge clock);
        check("scoreboard_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
